// File: rtl/residual_buffer_ctrl_if.sv
// -----------------------------------------------------------------------------
// residual_buffer_ctrl_if
// Groups the control, LPC-side, buffer-side and downstream handshake signals of
// one residual buffer sequencer.
//   slave  : controller side (drives the o* signals, receives the i* signals)
//   master : environment side (drives the i* signals, observes the o* signals)
// Signals:
//   iStart/iBlockLen/iAbort   block control
//   iResValid/iResidual       residual stream from the LPC stage
//   iDownReady                downstream coder backpressure
//   oBufReset/oBufValid/oBufEnable  buffer clear, write and read strobes
//   oDrainValid               buffer output valid toward the coder
//   oAbsSum/oCount            block statistics
//   oBusy/oDone/oError        status
// -----------------------------------------------------------------------------
interface residual_buffer_ctrl_if #(
   parameter int CNT_W  = 5,
   parameter int SUM_W  = 20,
   parameter int DATA_W = 16
);
   logic                     iStart;
   logic [CNT_W-1:0]         iBlockLen;
   logic                     iAbort;
   logic                     iResValid;
   logic signed [DATA_W-1:0] iResidual;
   logic                     iDownReady;
   logic                     oBufReset;
   logic                     oBufValid;
   logic                     oBufEnable;
   logic                     oDrainValid;
   logic [SUM_W-1:0]         oAbsSum;
   logic [CNT_W-1:0]         oCount;
   logic                     oBusy;
   logic                     oDone;
   logic                     oError;

   modport slave (
      input  iStart, iBlockLen, iAbort, iResValid, iResidual, iDownReady,
      output oBufReset, oBufValid, oBufEnable, oDrainValid,
             oAbsSum, oCount, oBusy, oDone, oError
   );

   modport master (
      output iStart, iBlockLen, iAbort, iResValid, iResidual, iDownReady,
      input  oBufReset, oBufValid, oBufEnable, oDrainValid,
             oAbsSum, oCount, oBusy, oDone, oError
   );
endinterface

// File: rtl/residual_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// residual_buffer_ctrl
// Sequencer for one residual buffer between the LPC residual generator and the
// Rice/entropy coder. Per block: clear the buffer, gate and count residual
// writes up to the programmed length while accumulating sum(|residual|), drain
// the buffer under downstream backpressure, then pulse completion.
// Ports:
//   iClock    system clock, rising edge
//   iReset_n  asynchronous active-low reset
//   bus       residual_buffer_ctrl_if.slave (control, LPC, buffer, downstream)
// -----------------------------------------------------------------------------
module residual_buffer_ctrl #(
   parameter int BLK_SIZE = 16,
   parameter int CNT_W    = 5,
   parameter int SUM_W    = 20,
   parameter int DATA_W   = 16
) (
   input  logic                    iClock,
   input  logic                    iReset_n,
   residual_buffer_ctrl_if.slave   bus
);

   localparam logic [CNT_W-1:0] LP_BLK = CNT_W'(BLK_SIZE);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FILL  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_len;
   logic [CNT_W-1:0]   r_count;
   logic [CNT_W-1:0]   r_rd_cnt;
   logic [SUM_W-1:0]   r_abs_sum;
   logic               r_abort;        // current CLEAR was entered by an abort
   logic               r_error;
   logic               r_drain_vld_p1;

   logic               w_wr;
   logic               w_rd;

   // Magnitude of a signed residual, one bit wider so |-2^(DATA_W-1)| is exact.
   function automatic logic [SUM_W-1:0] abs_ext(input logic signed [DATA_W-1:0] v);
      logic signed [DATA_W:0] w_ext;
      logic [DATA_W:0]        w_mag;
      w_ext = {v[DATA_W-1], v};
      w_mag = w_ext[DATA_W] ? $unsigned(-w_ext) : $unsigned(w_ext);
      return {{(SUM_W-DATA_W-1){1'b0}}, w_mag};
   endfunction

   // Abort wins over any write/read in the same cycle.
   always_comb begin
      w_wr = (r_state == S_FILL) && bus.iResValid && !bus.iAbort;
      w_rd = (r_state == S_DRAIN) && bus.iDownReady && (r_rd_cnt < r_len) && !bus.iAbort;
   end

   assign bus.oBufReset   = (r_state == S_CLEAR);
   assign bus.oBufValid   = w_wr;
   assign bus.oBufEnable  = w_rd;
   assign bus.oBusy       = (r_state != S_IDLE);
   assign bus.oDone       = (r_state == S_DONE) && !bus.iAbort;
   assign bus.oDrainValid = r_drain_vld_p1;
   assign bus.oAbsSum     = r_abs_sum;
   assign bus.oCount      = r_count;
   assign bus.oError      = r_error;

   always_ff @(posedge iClock or negedge iReset_n) begin
      if (!iReset_n) begin
         r_state        <= S_IDLE;
         r_len          <= '0;
         r_count        <= '0;
         r_rd_cnt       <= '0;
         r_abs_sum      <= '0;
         r_abort        <= 1'b0;
         r_error        <= 1'b0;
         r_drain_vld_p1 <= 1'b0;
      end else begin
         // p1: buffer output is valid one cycle after its read strobe
         r_drain_vld_p1 <= w_rd;

         if (bus.iAbort && (r_state != S_IDLE)) begin
            r_state <= S_CLEAR;
            r_abort <= 1'b1;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (bus.iStart) begin
                     if (bus.iBlockLen == '0) begin
                        r_error <= 1'b1;
                     end else begin
                        r_len   <= (bus.iBlockLen > LP_BLK) ? LP_BLK : bus.iBlockLen;
                        r_abort <= 1'b0;
                        r_state <= S_CLEAR;
                     end
                  end
               end
               S_CLEAR: begin
                  r_count   <= '0;
                  r_rd_cnt  <= '0;
                  r_abs_sum <= '0;
                  r_state   <= r_abort ? S_IDLE : S_FILL;
               end
               S_FILL: begin
                  if (w_wr) begin
                     r_count   <= r_count + CNT_W'(1);
                     r_abs_sum <= r_abs_sum + abs_ext(bus.iResidual);
                     if ((r_count + CNT_W'(1)) == r_len) r_state <= S_DRAIN;
                  end
               end
               S_DRAIN: begin
                  // Residuals arriving after the block is full are dropped.
                  if (bus.iResValid) r_error <= 1'b1;
                  if (w_rd) begin
                     r_rd_cnt <= r_rd_cnt + CNT_W'(1);
                     if ((r_rd_cnt + CNT_W'(1)) == r_len) r_state <= S_DONE;
                  end
               end
               S_DONE:  r_state <= S_IDLE;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_residual_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_residual_buffer_ctrl
// Directed bench for residual_buffer_ctrl: normal block, backpressure, abort,
// overflow write, clamped length, asynchronous reset mid-drain, zero length.
// -----------------------------------------------------------------------------
module tb_residual_buffer_ctrl;

   logic iClock = 1'b0;
   logic iReset_n;

   always #5 iClock = ~iClock;

   residual_buffer_ctrl_if #(.CNT_W(5), .SUM_W(20), .DATA_W(16)) bus ();

   residual_buffer_ctrl #(
      .BLK_SIZE(16), .CNT_W(5), .SUM_W(20), .DATA_W(16)
   ) u_dut (
      .iClock  (iClock),
      .iReset_n(iReset_n),
      .bus     (bus)
   );

   int n_pass  = 0;
   int n_total = 0;

   // Pulse counters sampled mid-cycle.
   int c_rst = 0, c_wr = 0, c_en = 0, c_dv = 0, c_done = 0;
   always @(negedge iClock) begin
      if (bus.oBufReset)   c_rst++;
      if (bus.oBufValid)   c_wr++;
      if (bus.oBufEnable)  c_en++;
      if (bus.oDrainValid) c_dv++;
      if (bus.oDone)       c_done++;
   end

   int b_rst, b_wr, b_en, b_dv, b_done;

   task automatic snap();
      b_rst = c_rst; b_wr = c_wr; b_en = c_en; b_dv = c_dv; b_done = c_done;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge iClock);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   // Pulse iStart for one cycle; returns in the cycle after the sampling edge.
   task automatic start(input logic [4:0] len);
      bus.iStart    = 1'b1;
      bus.iBlockLen = len;
      cyc();
      bus.iStart    = 1'b0;
   endtask

   task automatic send(input logic signed [15:0] r);
      bus.iResValid = 1'b1;
      bus.iResidual = r;
      cyc();
      bus.iResValid = 1'b0;
   endtask

   task automatic drain_to_idle();
      int k;
      k = 0;
      bus.iDownReady = 1'b1;
      while (bus.oBusy && k < 40) begin
         cyc();
         k++;
      end
      chk("drain_bound", 32'(k < 40), 1);
   endtask

   int rdy [5] = '{1, 0, 0, 1, 1};

   initial begin
      iReset_n       = 1'b0;
      bus.iStart     = 1'b0;
      bus.iBlockLen  = '0;
      bus.iAbort     = 1'b0;
      bus.iResValid  = 1'b0;
      bus.iResidual  = '0;
      bus.iDownReady = 1'b0;
      #12;
      chk("rst_busy",  bus.oBusy, 0);
      chk("rst_count", bus.oCount, 0);
      chk("rst_sum",   bus.oAbsSum, 0);
      chk("rst_err",   bus.oError, 0);
      chk("rst_done",  bus.oDone, 0);
      chk("rst_dv",    bus.oDrainValid, 0);
      @(posedge iClock); #1;
      iReset_n = 1'b1;
      cyc();

      // ---- len=4, residuals 5,-3,-32768,7, ready always ----
      snap();
      bus.iDownReady = 1'b1;
      start(5'd4);
      settle();
      chk("t1_clear", bus.oBufReset, 1);
      cyc();
      send(16'sd5); send(-16'sd3); send(-16'sd32768); send(16'sd7);
      settle();
      chk("t1_count", bus.oCount, 4);
      chk("t1_sum",   bus.oAbsSum, 32783);
      cyc();
      // cycle position was advanced by one; drain already started there
      chk("t1_en_cnt_mid", 32'(c_en - b_en), 1);
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("t1_en", bus.oBufEnable, 1);
         chk("t1_dv", bus.oDrainValid, 1);
         cyc();
      end
      settle();
      chk("t1_done",    bus.oDone, 1);
      chk("t1_done_dv", bus.oDrainValid, 1);
      chk("t1_done_en", bus.oBufEnable, 0);
      cyc();
      settle();
      chk("t1_idle",     bus.oBusy, 0);
      chk("t1_sum_hold", bus.oAbsSum, 32783);
      chk("t1_n_rst",  32'(c_rst - b_rst), 1);
      chk("t1_n_wr",   32'(c_wr - b_wr), 4);
      chk("t1_n_en",   32'(c_en - b_en), 4);
      chk("t1_n_dv",   32'(c_dv - b_dv), 4);
      chk("t1_n_done", 32'(c_done - b_done), 1);
      cyc();

      // ---- len=3 with ready 1,0,0,1,1 ----
      snap();
      bus.iDownReady = 1'b0;
      start(5'd3);
      cyc();
      send(16'sd1); send(16'sd2); send(16'sd3);
      for (int i = 0; i < 5; i++) begin
         bus.iDownReady = rdy[i][0];
         settle();
         chk("t2_en", bus.oBufEnable, 32'(rdy[i]));
         cyc();
      end
      settle();
      chk("t2_done", bus.oDone, 1);
      chk("t2_dv",   bus.oDrainValid, 1);
      chk("t2_n_en", 32'(c_en - b_en), 3);
      cyc();
      cyc();

      // ---- abort after 2 of 4 writes, then len=2 ----
      snap();
      start(5'd4);
      cyc();
      send(16'sd100); send(-16'sd50);
      bus.iAbort    = 1'b1;
      bus.iResValid = 1'b1;
      bus.iResidual = 16'sd9;
      settle();
      chk("ab_no_wr", bus.oBufValid, 0);
      cyc();
      bus.iAbort    = 1'b0;
      bus.iResValid = 1'b0;
      settle();
      chk("ab_clear", bus.oBufReset, 1);
      cyc();
      settle();
      chk("ab_idle",   bus.oBusy, 0);
      chk("ab_sum0",   bus.oAbsSum, 0);
      chk("ab_cnt0",   bus.oCount, 0);
      chk("ab_n_rst",  32'(c_rst - b_rst), 2);
      chk("ab_n_done", 32'(c_done - b_done), 0);
      snap();
      start(5'd2);
      cyc();
      send(-16'sd10); send(16'sd4);
      settle();
      chk("ab2_count", bus.oCount, 2);
      chk("ab2_sum",   bus.oAbsSum, 14);
      drain_to_idle();
      chk("ab2_n_done", 32'(c_done - b_done), 1);
      chk("ab2_n_en",   32'(c_en - b_en), 2);
      cyc();

      // ---- extra residual after a len=4 fill ----
      chk("ov_err0", bus.oError, 0);
      snap();
      start(5'd4);
      cyc();
      send(16'sd1); send(-16'sd1); send(16'sd1); send(-16'sd1);
      bus.iDownReady = 1'b1;
      bus.iResValid  = 1'b1;
      bus.iResidual  = 16'sd5;
      settle();
      chk("ov_no_wr", bus.oBufValid, 0);
      cyc();
      bus.iResValid = 1'b0;
      settle();
      chk("ov_err1",  bus.oError, 1);
      chk("ov_count", bus.oCount, 4);
      chk("ov_sum",   bus.oAbsSum, 4);
      drain_to_idle();
      chk("ov_n_en", 32'(c_en - b_en), 4);
      chk("ov_n_wr", 32'(c_wr - b_wr), 4);
      cyc();

      // ---- len=20 clamps to 16; stall; async reset mid-drain ----
      snap();
      bus.iDownReady = 1'b0;
      start(5'd20);
      cyc();
      for (int i = 0; i < 16; i++) send(-16'sd2);
      settle();
      chk("cl_count", bus.oCount, 16);
      chk("cl_sum",   bus.oAbsSum, 32);
      chk("cl_busy",  bus.oBusy, 1);
      chk("cl_n_wr",  32'(c_wr - b_wr), 16);
      cyc(); cyc(); cyc();
      settle();
      chk("cl_stall_en", bus.oBufEnable, 0);
      chk("cl_stall_dv", bus.oDrainValid, 0);
      bus.iDownReady = 1'b1;
      cyc(); cyc();
      settle();
      chk("cl_dv_pre", bus.oDrainValid, 1);
      iReset_n = 1'b0;
      #1;
      chk("ar_busy",  bus.oBusy, 0);
      chk("ar_en",    bus.oBufEnable, 0);
      chk("ar_dv",    bus.oDrainValid, 0);
      chk("ar_count", bus.oCount, 0);
      chk("ar_sum",   bus.oAbsSum, 0);
      chk("ar_err",   bus.oError, 0);
      cyc();
      iReset_n = 1'b1;
      bus.iDownReady = 1'b0;
      cyc();
      settle();
      chk("ar_idle", bus.oBusy, 0);
      cyc();

      // ---- zero length start ----
      start(5'd0);
      settle();
      chk("z_busy",  bus.oBusy, 0);
      chk("z_err",   bus.oError, 1);
      chk("z_clear", bus.oBufReset, 0);
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
